// File: rtl/uart_pkg.sv
// Shared types and elaboration-time helpers for the streaming UART transmitter.
// The optional parity bit is controlled by the UART_TX_PARITY_EN macro.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        GAP
    } uart_tx_state_t;

    localparam int MIN_CLKS_PER_BIT = 2;
    localparam int MIN_DATA_BITS    = 5;
    localparam int MAX_DATA_BITS    = 8;
    localparam int MIN_STOP_BITS    = 1;
    localparam int MAX_STOP_BITS    = 2;
    localparam int MIN_FIFO_DEPTH   = 2;

    // Width of a counter that runs 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic bit params_ok(input int clks_per_bit, input int data_bits,
                                     input int stop_bits, input int gap_clks,
                                     input int fifo_depth, input int parity_odd);
        return (clks_per_bit >= MIN_CLKS_PER_BIT) &&
               (data_bits >= MIN_DATA_BITS) && (data_bits <= MAX_DATA_BITS) &&
               (stop_bits >= MIN_STOP_BITS) && (stop_bits <= MAX_STOP_BITS) &&
               (gap_clks >= 0) &&
               (fifo_depth >= MIN_FIFO_DEPTH) && ((fifo_depth & (fifo_depth - 1)) == 0) &&
               ((parity_odd == 0) || (parity_odd == 1));
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous byte FIFO feeding the UART transmitter; the occupancy count,
// not the pointers, tells full from empty so pointers simply wrap.
module uart_sync_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic                          pop,
    input  logic [DATA_BITS-1:0]          push_data,
    output logic [DATA_BITS-1:0]          head,
    output logic [$clog2(FIFO_DEPTH):0]   count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic                 push_ok;
    logic                 pop_ok;

    assign push_ok = push && (count != CNT_W'(FIFO_DEPTH));
    assign pop_ok  = pop && (count != '0);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: stale entries are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/uart_tx_stream.sv
// UART transmitter with an input FIFO: start, LSB-first data, optional parity
// (UART_TX_PARITY_EN), stop bits and an idle gap between frames.
module uart_tx_stream
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1,
    parameter int GAP_CLKS     = 1,
    parameter int FIFO_DEPTH   = 16,
    parameter int PARITY_ODD   = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic [DATA_BITS-1:0]          in_data,
    output logic                          in_ready,
    output logic                          txd,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam bit PARAMS_OK = params_ok(CLKS_PER_BIT, DATA_BITS, STOP_BITS,
                                         GAP_CLKS, FIFO_DEPTH, PARITY_ODD);
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int BAUD_W = cnt_width(CLKS_PER_BIT);
    localparam int BIT_W  = cnt_width(DATA_BITS);
    localparam int STOP_W = cnt_width(STOP_BITS);
    localparam int GAP_W  = cnt_width((GAP_CLKS > 0) ? GAP_CLKS : 1);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);
    localparam logic [STOP_W-1:0] STOP_LAST = STOP_W'(STOP_BITS - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((GAP_CLKS > 0) ? GAP_CLKS - 1 : 0);

    if (!PARAMS_OK) begin : g_bad_params
        $error("uart_tx_stream: parameter out of supported range");
    end

    uart_tx_state_t       state;
    uart_tx_state_t       next_state;
    logic                 push;
    logic                 pop;
    logic [DATA_BITS-1:0] head;
    logic [DATA_BITS-1:0] shift;
    logic [BAUD_W-1:0]    baud_cnt;
    logic [BIT_W-1:0]     bit_idx;
    logic [STOP_W-1:0]    stop_idx;
    logic [GAP_W-1:0]     gap_cnt;
    logic                 baud_last;
    logic                 bit_last;
    logic                 stop_last;
    logic                 gap_last;
`ifdef UART_TX_PARITY_EN
    logic                 par_bit;
`endif

    assign in_ready  = (fifo_count != CNT_W'(FIFO_DEPTH));
    assign push      = in_valid && in_ready;
    assign busy      = (state != IDLE) || (fifo_count != '0);
    assign baud_last = (baud_cnt == BAUD_LAST);
    assign bit_last  = (bit_idx == BIT_LAST);
    assign stop_last = (stop_idx == STOP_LAST);
    assign gap_last  = (gap_cnt == GAP_LAST);

    uart_sync_fifo #(
        .DATA_BITS  (DATA_BITS),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .pop        (pop),
        .push_data  (in_data),
        .head       (head),
        .count      (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // txd is decoded from registered state only, so the line never waits a cycle
    // behind the FSM; with no gap the last stop bit hands straight to the next start.
    always_comb begin
        next_state = state;
        pop        = 1'b0;
        txd        = 1'b1;
        case (state)
            IDLE: begin
                if (fifo_count != '0) begin
                    pop        = 1'b1;
                    next_state = START;
                end
            end
            START: begin
                txd = 1'b0;
                if (baud_last) begin
                    next_state = DATA;
                end
            end
            DATA: begin
                txd = shift[0];
                if (baud_last && bit_last) begin
`ifdef UART_TX_PARITY_EN
                    next_state = PARITY;
`else
                    next_state = STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                txd = par_bit;
                if (baud_last) begin
                    next_state = STOP;
                end
            end
`endif
            STOP: begin
                if (baud_last && stop_last) begin
                    if (GAP_CLKS > 0) begin
                        next_state = GAP;
                    end else if (fifo_count != '0) begin
                        pop        = 1'b1;
                        next_state = START;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            GAP: begin
                if (gap_last) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift    <= '0;
            baud_cnt <= '0;
            bit_idx  <= '0;
            stop_idx <= '0;
            gap_cnt  <= '0;
        end else begin
            if (pop) begin
                shift <= head;
            end else if ((state == DATA) && baud_last) begin
                shift <= shift >> 1;
            end

            if ((state == START) || (state == DATA) || (state == PARITY) || (state == STOP)) begin
                baud_cnt <= baud_last ? '0 : baud_cnt + 1'b1;
            end else begin
                baud_cnt <= '0;
            end

            if (state != DATA) begin
                bit_idx <= '0;
            end else if (baud_last) begin
                bit_idx <= bit_last ? '0 : bit_idx + 1'b1;
            end

            if (state != STOP) begin
                stop_idx <= '0;
            end else if (baud_last) begin
                stop_idx <= stop_last ? '0 : stop_idx + 1'b1;
            end

            if (state == GAP) begin
                gap_cnt <= gap_last ? '0 : gap_cnt + 1'b1;
            end else begin
                gap_cnt <= '0;
            end
        end
    end

`ifdef UART_TX_PARITY_EN
    // Parity is fixed at pop time from the whole byte, before the shifter consumes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            par_bit <= 1'b0;
        end else if (pop) begin
            par_bit <= (^head) ^ 1'(PARITY_ODD);
        end
    end
`endif

endmodule
